// File: rtl/rs232_packet_tx.sv
// Packet transmitter for the RS232 command/response link: frames a latched
// address and data word as an 8-byte packet and sends it as UART 8N1, LSB first.
module rs232_packet_tx #(
  parameter int CLKS_PER_BIT = 2580,
  parameter int GAP_CLKS     = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_start,
  input  logic [6:0]  addr_in,
  input  logic [31:0] data_in,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int CNT_W = (CLKS_PER_BIT + GAP_CLKS > 1) ? $clog2(CLKS_PER_BIT + GAP_CLKS) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4,
    GAP   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [2:0]       byte_q, byte_d;
  logic [7:0]       shift_q, shift_d;
  logic [6:0]       addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       checksum;
  logic [7:0]       cur_byte;

  // Handshake: tx_start is a request honoured only while busy is low (IDLE);
  // busy rises on the accepting edge and falls together with the done pulse.
  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

  assign checksum = {1'b0, addr_q} ^ data_q[7:0] ^ data_q[15:8] ^ data_q[23:16] ^ data_q[31:24];

  always_comb begin
    cur_byte = 8'h03;
    case (byte_q)
      3'd0:    cur_byte = 8'h02;
      3'd1:    cur_byte = {1'b0, addr_q};
      3'd2:    cur_byte = data_q[7:0];
      3'd3:    cur_byte = data_q[15:8];
      3'd4:    cur_byte = data_q[23:16];
      3'd5:    cur_byte = data_q[31:24];
      3'd6:    cur_byte = checksum;
      default: cur_byte = 8'h03;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shift_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // tx_d is the level the line takes in the state being entered, so the
  // serial output is always a flop with no path from the inputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    addr_d  = addr_q;
    data_d  = data_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (tx_start) begin
          addr_d  = addr_in;
          data_d  = data_in;
          busy_d  = 1'b1;
          byte_d  = '0;
          bit_d   = '0;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        shift_d = cur_byte;
        cnt_d   = '0;
        tx_d    = 1'b0;
        state_d = START;
      end
      START: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (byte_q == 3'd7) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (GAP_CLKS > 0) begin
            state_d = GAP;
          end else begin
            byte_d  = byte_q + 3'd1;
            state_d = LOAD;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          byte_d  = byte_q + 3'd1;
          state_d = LOAD;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule
